// File: rtl/artec_dma_axi_writer.sv
// DMA write engine: turns {addr, num, eof} tasks plus a beat stream into AXI4 INCR write bursts.
// Define ARTEC_DMA_WR_FRAME_CNT_EN to add the frame_done_o / frame_cnt_o ports.
module artec_dma_axi_writer #(
    parameter int PACKET_SIZE     = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    localparam int NUM_W          = $clog2(PACKET_SIZE) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,
    input  logic [ADDR_WIDTH-1:0]   task_addr_i,
    input  logic [NUM_W-1:0]        task_num_i,
    input  logic                    task_eof_i,
    input  logic                    data_valid_i,
    output logic                    data_ready_o,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    busy_o,
    output logic                    err_o,
`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
    output logic                    frame_done_o,
    output logic [31:0]             frame_cnt_o,
`endif
    output logic                    dbg_aw_state
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] DEPTH = (PW + 1)'(MAX_OUTSTANDING);

    typedef enum logic {AW_IDLE = 1'b0, AW_ADDR = 1'b1} aw_state_t;

    aw_state_t          aw_state;
    logic [NUM_W:0]     len_mem [MAX_OUTSTANDING];
    logic [PW:0]        wr_ptr;
    logic [PW:0]        w_rd_ptr;
    logic [PW-1:0]      b_rd_ptr;
    logic [PW:0]        outst;
    logic [PW:0]        w_pending;
    logic [NUM_W-1:0]   aw_num;
    logic               aw_eof;
    logic               task_zero;
    logic               aw_fire;
    logic               w_fire;
    logic               w_start;
    logic               b_legal;
    logic               w_active;
    logic [NUM_W-1:0]   w_beat;
    logic [NUM_W-1:0]   w_last_idx;
    logic [NUM_W:0]     w_head;
    logic [NUM_W:0]     b_head;
    logic               unused_bits;

    assign m_awsize     = 3'($clog2(DATA_WIDTH / 8));
    assign m_awburst    = 2'b01;
    assign m_wstrb      = '1;
    assign m_bready     = 1'b1;
    assign m_wdata      = data_i;
    assign dbg_aw_state = aw_state;

    // All streams use valid/ready: a transfer happens on a rising clk edge where both are high;
    // the source holds payload stable while valid is high and not yet accepted.
    assign w_pending    = wr_ptr - w_rd_ptr;
    assign task_ready_o = (aw_state == AW_IDLE) && task_valid_i && (outst < DEPTH) && (w_pending < DEPTH);
    assign task_zero    = task_ready_o && (task_num_i == '0);
    assign aw_fire      = m_awvalid && m_awready;
    assign b_legal      = m_bvalid && (outst != '0);

    assign w_head       = len_mem[w_rd_ptr[PW-1:0]];
    assign b_head       = len_mem[b_rd_ptr];
    assign m_wvalid     = data_valid_i && w_active;
    assign data_ready_o = m_wready && w_active;
    assign m_wlast      = w_active && (w_beat == w_last_idx);
    assign w_fire       = m_wvalid && m_wready;
    assign w_start      = (!w_active || (w_fire && m_wlast)) && (w_pending != '0);

    assign busy_o       = (outst != '0) || (aw_state == AW_ADDR) || w_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_state  <= AW_IDLE;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            aw_num    <= '0;
            aw_eof    <= 1'b0;
        end else begin
            case (aw_state)
                AW_IDLE: begin
                    if (task_ready_o && !task_zero) begin
                        m_awaddr  <= task_addr_i;
                        m_awlen   <= 8'(task_num_i - NUM_W'(1));
                        aw_num    <= task_num_i;
                        aw_eof    <= task_eof_i;
                        m_awvalid <= 1'b1;
                        aw_state  <= AW_ADDR;
                    end
                end
                AW_ADDR: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        aw_state  <= AW_IDLE;
                    end
                end
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    // Entries live from AW handshake until their B; the W side reads ahead with its own pointer.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            len_mem[wr_ptr[PW-1:0]] <= {aw_num, aw_eof};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            w_rd_ptr <= '0;
            b_rd_ptr <= '0;
            outst    <= '0;
        end else begin
            if (aw_fire) wr_ptr <= wr_ptr + (PW + 1)'(1);
            if (w_start) w_rd_ptr <= w_rd_ptr + (PW + 1)'(1);
            if (b_legal) b_rd_ptr <= b_rd_ptr + PW'(1);
            case ({aw_fire, b_legal})
                2'b10:   outst <= outst + (PW + 1)'(1);
                2'b01:   outst <= outst - (PW + 1)'(1);
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_active   <= 1'b0;
            w_beat     <= '0;
            w_last_idx <= '0;
        end else if (w_start) begin
            w_active   <= 1'b1;
            w_beat     <= '0;
            w_last_idx <= w_head[NUM_W:1] - NUM_W'(1);
        end else if (w_fire) begin
            if (m_wlast) begin
                w_active <= 1'b0;
            end else begin
                w_beat <= w_beat + NUM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (clear_i) begin
            err_o <= 1'b0;
        end else if (task_zero || (m_bvalid && ((m_bresp != 2'b00) || (outst == '0)))) begin
            err_o <= 1'b1;
        end
    end

`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            frame_done_o <= b_legal && b_head[0];
            if (clear_i) begin
                frame_cnt_o <= '0;
            end else if (b_legal && b_head[0]) begin
                frame_cnt_o <= frame_cnt_o + 32'd1;
            end
        end
    end

    assign unused_bits = ^{w_head[0], b_head[NUM_W:1]};
`else
    assign unused_bits = ^{w_head[0], b_head};
`endif

endmodule

// File: tb/tb_artec_dma_axi_writer.sv
// Directed bench for artec_dma_axi_writer: queued stimulus drivers, an AXI slave model and a
// monitor that pops expected AW/W values and tracks the error / frame state independently.
module tb_artec_dma_axi_writer;

    localparam int DW  = 64;
    localparam int AWD = 32;
    localparam int PS  = 32;
    localparam int MO  = 8;
    localparam int NW  = $clog2(PS) + 1;

    typedef struct {
        logic [AWD-1:0] addr;
        logic [NW-1:0]  num;
        logic           eof;
    } task_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_i;
    logic task_valid_i, task_ready_o, task_eof_i;
    logic [AWD-1:0] task_addr_i;
    logic [NW-1:0]  task_num_i;
    logic data_valid_i, data_ready_o;
    logic [DW-1:0]  data_i;
    logic [AWD-1:0] m_awaddr;
    logic [7:0]     m_awlen;
    logic [2:0]     m_awsize;
    logic [1:0]     m_awburst;
    logic m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic m_wlast, m_wvalid, m_wready;
    logic [1:0] m_bresp;
    logic m_bvalid, m_bready;
    logic busy_o, err_o, dbg_aw_state;
`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
    logic        frame_done_o;
    logic [31:0] frame_cnt_o;
`endif

    artec_dma_axi_writer #(
        .PACKET_SIZE(PS), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o), .task_addr_i(task_addr_i),
        .task_num_i(task_num_i), .task_eof_i(task_eof_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy_o(busy_o), .err_o(err_o),
`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
        .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
`endif
        .dbg_aw_state(dbg_aw_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    task_t          task_q[$];
    logic [DW-1:0]  data_q[$];
    logic [AWD+7:0] exp_aw_q[$];
    logic [DW:0]    exp_w_q[$];
    logic [1:0]     bresp_q[$];
    logic           eof_q[$];

    int  n_checks = 0;
    int  n_fail = 0;
    int  aw_hs = 0;
    int  w_hs = 0;
    int  b_hs = 0;
    int  frame_pulses = 0;
    int  b_pending = 0;
    int  b_allow = -1;
    int  exp_outst = 0;
    logic exp_err = 1'b0;
    logic exp_fd = 1'b0;
    logic [31:0] exp_fc = '0;
    logic aw_due = 1'b0;
    logic wr_toggle = 1'b0;
    logic drv_t_take, drv_d_take;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_task(input logic [AWD-1:0] addr, input int num, input logic eof);
        task_t t;
        t.addr = addr;
        t.num  = NW'(num);
        t.eof  = eof;
        task_q.push_back(t);
        if (num != 0) begin
            exp_aw_q.push_back({addr, 8'(num - 1)});
            eof_q.push_back(eof);
            for (int k = 0; k < num; k++) begin
                data_q.push_back({addr, 32'(k)});
                exp_w_q.push_back({(k == num - 1), addr, 32'(k)});
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((task_q.size() != 0 || data_q.size() != 0 || exp_aw_q.size() != 0 ||
                exp_w_q.size() != 0 || b_pending != 0 || m_bvalid) && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < max_cycles), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
    endtask

    // driver: task stream, data stream, W ready pattern and B responder
    initial begin
        task_valid_i = 1'b0; task_addr_i = '0; task_num_i = '0; task_eof_i = 1'b0;
        data_valid_i = 1'b0; data_i = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
        forever begin
            @(negedge clk);
            drv_t_take = task_valid_i && task_ready_o;
            drv_d_take = data_valid_i && data_ready_o;
            @(posedge clk);
            #1;
            if (drv_t_take) void'(task_q.pop_front());
            if (drv_d_take) void'(data_q.pop_front());
            task_valid_i = (task_q.size() != 0);
            if (task_valid_i) begin
                task_addr_i = task_q[0].addr;
                task_num_i  = task_q[0].num;
                task_eof_i  = task_q[0].eof;
            end
            data_valid_i = (data_q.size() != 0);
            if (data_valid_i) data_i = data_q[0];
            m_wready = wr_toggle ? ~m_wready : 1'b1;
            if (m_bvalid) begin
                m_bvalid = 1'b0;
            end else if (b_pending > 0 && b_allow != 0) begin
                m_bvalid = 1'b1;
                m_bresp  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
                b_pending--;
                if (b_allow > 0) b_allow--;
            end
        end
    end

    // monitor: compares every output handshake against the expected queues
    initial begin
        logic [AWD+7:0] ea;
        logic [DW:0]    ew;
        logic           set_err;
        logic           b_ok;
        logic           eof_hit;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("err_o", 64'(err_o), 64'(exp_err));
`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
                check("frame_done_o", 64'(frame_done_o), 64'(exp_fd));
                check("frame_cnt_o", 64'(frame_cnt_o), 64'(exp_fc));
                if (frame_done_o) frame_pulses++;
`endif
                if (aw_due) check("aw_latency", 64'(m_awvalid), 64'd1);
                aw_due = task_valid_i && task_ready_o && (task_num_i != '0);
                set_err = task_valid_i && task_ready_o && (task_num_i == '0);
                b_ok = m_bvalid && (exp_outst != 0);
                if (m_bvalid && (m_bresp != 2'b00 || exp_outst == 0)) set_err = 1'b1;
                if (m_awvalid && m_awready) begin
                    aw_hs++;
                    if (exp_aw_q.size() == 0) begin
                        check("aw_unexpected", 64'(m_awaddr), 64'd0 - 64'd1);
                    end else begin
                        ea = exp_aw_q.pop_front();
                        check("awaddr", 64'(m_awaddr), 64'(ea[AWD+7:8]));
                        check("awlen", 64'(m_awlen), 64'(ea[7:0]));
                        check("awsize", 64'(m_awsize), 64'd3);
                        check("awburst", 64'(m_awburst), 64'd1);
                    end
                end
                if (m_wvalid) check("data_ready_mirror", 64'(data_ready_o), 64'(m_wready));
                if (m_wvalid && m_wready) begin
                    w_hs++;
                    check("wstrb", 64'(m_wstrb), 64'hFF);
                    if (exp_w_q.size() == 0) begin
                        check("w_unexpected", m_wdata, ~m_wdata);
                    end else begin
                        ew = exp_w_q.pop_front();
                        check("wdata", m_wdata, ew[DW-1:0]);
                        check("wlast", 64'(m_wlast), 64'(ew[DW]));
                    end
                    if (m_wlast) b_pending++;
                end
                eof_hit = 1'b0;
                if (m_bvalid) b_hs++;
                if (b_ok && eof_q.size() != 0) eof_hit = eof_q.pop_front();
                exp_err = clear_i ? 1'b0 : (exp_err | set_err);
                exp_fd  = b_ok && eof_hit;
                exp_fc  = clear_i ? 32'd0 : (exp_fc + 32'(exp_fd));
                if (m_awvalid && m_awready) exp_outst++;
                if (b_ok) exp_outst--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // directed test sequence
    initial begin
        int base_aw;
        int base_w;
        int base_fp;
        clear_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_task_ready", 64'(task_ready_o), 64'd0);
        check("rst_data_ready", 64'(data_ready_o), 64'd0);
        check("rst_awvalid", 64'(m_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_wvalid), 64'd0);
        check("rst_wlast", 64'(m_wlast), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_bready", 64'(m_bready), 64'd1);
        check("rst_aw_state", 64'(dbg_aw_state), 64'd0);
        check("rst_awsize", 64'(m_awsize), 64'd3);
        check("rst_awburst", 64'(m_awburst), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // single 32-beat burst
        base_aw = aw_hs; base_w = w_hs;
        push_task(32'h1000_0000, 32, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_busy_active", 64'(busy_o), 64'd1);
        wait_idle(400);
        check("t1_busy_done", 64'(busy_o), 64'd0);
        check("t1_aw_count", 64'(aw_hs - base_aw), 64'd1);
        check("t1_w_count", 64'(w_hs - base_w), 64'd32);

        // W ready toggling every cycle
        wr_toggle = 1'b1;
        base_w = w_hs;
        push_task(32'h2000_0040, 4, 1'b0);
        wait_idle(200);
        check("t2_w_count", 64'(w_hs - base_w), 64'd4);
        wr_toggle = 1'b0;

        // outstanding limit with B held off
        b_allow = 0;
        base_aw = aw_hs;
        for (int i = 0; i < 10; i++) push_task(32'h3000_0000 + 32'(i * 64), 1, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t3_aw_capped", 64'(aw_hs - base_aw), 64'd8);
        check("t3_task_valid", 64'(task_valid_i), 64'd1);
        check("t3_task_ready_low", 64'(task_ready_o), 64'd0);
        check("t3_busy", 64'(busy_o), 64'd1);
        b_allow = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_aw_after_one_b", 64'(aw_hs - base_aw), 64'd9);
        b_allow = -1;
        wait_idle(300);
        check("t3_aw_total", 64'(aw_hs - base_aw), 64'd10);
        check("t3_err_clean", 64'(err_o), 64'd0);

        // SLVERR on the middle burst, sticky until clear
        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00);
        for (int i = 0; i < 3; i++) push_task(32'h4000_0000 + 32'(i * 128), 2, 1'b0);
        wait_idle(300);
        check("t4_err_sticky", 64'(err_o), 64'd1);
        pulse_clear();
        @(negedge clk);
        check("t4_err_cleared", 64'(err_o), 64'd0);

        // zero-length task is swallowed and flagged
        base_aw = aw_hs;
        push_task(32'h5000_1000, 0, 1'b0);
        push_task(32'h5000_0000, 2, 1'b0);
        wait_idle(200);
        check("t5_err", 64'(err_o), 64'd1);
        check("t5_aw_count", 64'(aw_hs - base_aw), 64'd1);
        pulse_clear();

`ifdef ARTEC_DMA_WR_FRAME_CNT_EN
        // frame pulse on the eof burst's response
        base_fp = frame_pulses;
        push_task(32'h6000_0000, 1, 1'b0);
        push_task(32'h6000_0040, 1, 1'b0);
        push_task(32'h6000_0080, 1, 1'b1);
        wait_idle(200);
        check("t6_frame_pulses", 64'(frame_pulses - base_fp), 64'd1);
        check("t6_frame_cnt", 64'(frame_cnt_o), 64'd1);
        pulse_clear();
        @(negedge clk);
        check("t6_frame_cnt_clr", 64'(frame_cnt_o), 64'd0);
`else
        base_fp = frame_pulses;
        check("t6_no_frame_pulses", 64'(frame_pulses - base_fp), 64'd0);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
